// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants, sync polarity values and the coordinate
// type used by the timing generator and the pixel-colour blocks.
package vga_timing_pkg;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BP_DEF      = 48;
  localparam int H_TOTAL_DEF   = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BP_DEF      = 33;
  localparam int V_TOTAL_DEF   = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;

endpackage

// File: rtl/vga_pixel_tick.sv
// Pixel-rate divider: one tick every CLK_DIV enabled system clocks; the phase
// is frozen while en is low.
module vga_pixel_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  generate
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
      $error("vga_pixel_tick: CLK_DIV must be in 1..16");
    end
  endgenerate

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;

  always_comb begin
    tick      = en && (div_cnt_q == DIV_LAST);
    div_cnt_d = div_cnt_q;
    if (tick) begin
      div_cnt_d = '0;
    end else if (en) begin
      div_cnt_d = div_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: H/V counters advanced on pixel ticks, with
// registered sync, display-enable and coordinate outputs.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   CLK_DIV   = 4,
  parameter int   H_VISIBLE = H_VISIBLE_DEF,
  parameter int   H_FP      = H_FP_DEF,
  parameter int   H_SYNC    = H_SYNC_DEF,
  parameter int   H_BP      = H_BP_DEF,
  parameter int   V_VISIBLE = V_VISIBLE_DEF,
  parameter int   V_FP      = V_FP_DEF,
  parameter int   V_SYNC    = V_SYNC_DEF,
  parameter int   V_BP      = V_BP_DEF,
  parameter logic SYNC_POL  = SYNC_ACTIVE_LOW
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  output logic       h_sync,
  output logic       v_sync,
  output logic       DE,
  output logic [9:0] x_pixel,
  output logic [9:0] y_pixel,
  output logic       p_tick,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS_C  = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS_C  = coord_t'(V_VISIBLE);
  localparam coord_t HS_FIRST = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t HS_LAST  = coord_t'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam coord_t VS_FIRST = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t VS_LAST  = coord_t'(V_VISIBLE + V_FP + V_SYNC - 1);

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
  endgenerate

  logic   tick;
  coord_t h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic   de_q, de_d, h_sync_q, h_sync_d, v_sync_q, v_sync_d;
  coord_t x_q, x_d, y_q, y_d;
  logic   p_tick_q, p_tick_d, frame_start_q, frame_start_d;

  vga_pixel_tick #(.CLK_DIV(CLK_DIV)) u_pixel_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .tick    (tick)
  );

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (tick) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  // Outputs decode the post-increment counts so they line up with x/y.
  always_comb begin
    de_d          = de_q;
    h_sync_d      = h_sync_q;
    v_sync_d      = v_sync_q;
    x_d           = x_q;
    y_d           = y_q;
    p_tick_d      = tick;
    frame_start_d = 1'b0;
    if (tick) begin
      x_d           = h_cnt_d;
      y_d           = v_cnt_d;
      de_d          = (h_cnt_d < H_VIS_C) && (v_cnt_d < V_VIS_C);
      h_sync_d      = (h_cnt_d >= HS_FIRST && h_cnt_d <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
      v_sync_d      = (v_cnt_d >= VS_FIRST && v_cnt_d <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
      frame_start_d = (h_cnt_d == '0) && (v_cnt_d == '0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_q       <= H_LAST;
      v_cnt_q       <= V_LAST;
      de_q          <= 1'b0;
      h_sync_q      <= ~SYNC_POL;
      v_sync_q      <= ~SYNC_POL;
      x_q           <= '0;
      y_q           <= '0;
      p_tick_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      de_q          <= de_d;
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      x_q           <= x_d;
      y_q           <= y_d;
      p_tick_q      <= p_tick_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign h_sync      = h_sync_q;
  assign v_sync      = v_sync_q;
  assign DE          = de_q;
  assign x_pixel     = x_q;
  assign y_pixel     = y_q;
  assign p_tick      = p_tick_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized-enable bench: a small raster with CLK_DIV=3 and the full 640x480
// raster with CLK_DIV=1 and active-high sync, both checked against a tick-count model.
module tb_vga_timing_gen;

  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic [9:0] x;
    logic [9:0] y;
  } vis_t;

  // Small raster: 32 x 13 pixels, 416 ticks per frame.
  localparam int A_DIV = 3;
  localparam int A_HV = 20, A_HFP = 3, A_HS = 5, A_HBP = 4;
  localparam int A_VV = 6,  A_VFP = 2, A_VS = 2, A_VBP = 3;
  localparam logic A_POL = 1'b0;

  localparam int B_DIV = 1;
  localparam int B_HV = 640, B_HFP = 16, B_HS = 96, B_HBP = 48;
  localparam int B_VV = 480, B_VFP = 10, B_VS = 2,  B_VBP = 33;
  localparam logic B_POL = 1'b1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic en = 1'b0;

  logic       a_hsync, a_vsync, a_de, a_ptick, a_fs;
  logic [9:0] a_x, a_y;
  logic       b_hsync, b_vsync, b_de, b_ptick, b_fs;
  logic [9:0] b_x, b_y;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CLK_DIV(A_DIV), .H_VISIBLE(A_HV), .H_FP(A_HFP), .H_SYNC(A_HS), .H_BP(A_HBP),
    .V_VISIBLE(A_VV), .V_FP(A_VFP), .V_SYNC(A_VS), .V_BP(A_VBP), .SYNC_POL(A_POL)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .en(en),
    .h_sync(a_hsync), .v_sync(a_vsync), .DE(a_de),
    .x_pixel(a_x), .y_pixel(a_y), .p_tick(a_ptick), .frame_start(a_fs)
  );

  vga_timing_gen #(
    .CLK_DIV(B_DIV), .SYNC_POL(B_POL)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .en(en),
    .h_sync(b_hsync), .v_sync(b_vsync), .DE(b_de),
    .x_pixel(b_x), .y_pixel(b_y), .p_tick(b_ptick), .frame_start(b_fs)
  );

  // Model state: enabled clocks and pixel ticks since reset, plus last-edge tick.
  longint a_e = 0, a_t = 0, b_e = 0, b_t = 0;
  logic   a_tick = 1'b0, b_tick = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_e <= 0; a_t <= 0; a_tick <= 1'b0;
      b_e <= 0; b_t <= 0; b_tick <= 1'b0;
    end else if (en) begin
      a_e    <= a_e + 1;
      a_tick <= ((a_e + 1) % A_DIV) == 0;
      a_t    <= a_t + (((a_e + 1) % A_DIV) == 0 ? 1 : 0);
      b_e    <= b_e + 1;
      b_tick <= ((b_e + 1) % B_DIV) == 0;
      b_t    <= b_t + (((b_e + 1) % B_DIV) == 0 ? 1 : 0);
    end else begin
      a_tick <= 1'b0;
      b_tick <= 1'b0;
    end
  end

  // Raster position after t ticks: the counters start on the last pixel, so
  // tick number t lands on linear index (t-1) mod frame size.
  function automatic vis_t raster(input longint t, input int hv, input int hfp,
                                  input int hsw, input int hbp, input int vv,
                                  input int vfp, input int vsw, input int vbp,
                                  input logic pol);
    vis_t   r;
    int     ht, vt, xi, yi;
    longint idx;
    ht = hv + hfp + hsw + hbp;
    vt = vv + vfp + vsw + vbp;
    if (t == 0) begin
      r.de = 1'b0; r.hs = ~pol; r.vs = ~pol; r.x = '0; r.y = '0;
      return r;
    end
    idx  = (t - 1) % (longint'(ht) * vt);
    xi   = int'(idx % ht);
    yi   = int'(idx / ht);
    r.x  = 10'(xi);
    r.y  = 10'(yi);
    r.de = (xi < hv) && (yi < vv);
    r.hs = (xi >= hv + hfp && xi < hv + hfp + hsw) ? pol : ~pol;
    r.vs = (yi >= vv + vfp && yi < vv + vfp + vsw) ? pol : ~pol;
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    vis_t ea, eb;
    ea = raster(a_t, A_HV, A_HFP, A_HS, A_HBP, A_VV, A_VFP, A_VS, A_VBP, A_POL);
    eb = raster(b_t, B_HV, B_HFP, B_HS, B_HBP, B_VV, B_VFP, B_VS, B_VBP, B_POL);
    check_eq("a_x",      32'(a_x),     32'(ea.x));
    check_eq("a_y",      32'(a_y),     32'(ea.y));
    check_eq("a_de",     32'(a_de),    32'(ea.de));
    check_eq("a_hsync",  32'(a_hsync), 32'(ea.hs));
    check_eq("a_vsync",  32'(a_vsync), 32'(ea.vs));
    check_eq("a_ptick",  32'(a_ptick), 32'(a_tick));
    check_eq("a_fstart", 32'(a_fs),    32'(a_tick && a_t != 0 && ea.x == 0 && ea.y == 0));
    check_eq("b_x",      32'(b_x),     32'(eb.x));
    check_eq("b_y",      32'(b_y),     32'(eb.y));
    check_eq("b_de",     32'(b_de),    32'(eb.de));
    check_eq("b_hsync",  32'(b_hsync), 32'(eb.hs));
    check_eq("b_vsync",  32'(b_vsync), 32'(eb.vs));
    check_eq("b_ptick",  32'(b_ptick), 32'(b_tick));
    check_eq("b_fstart", 32'(b_fs),    32'(b_tick && b_t != 0 && eb.x == 0 && eb.y == 0));
  endtask

  // mode 0: en held high; mode 1: mostly high, random drops and 50-clk freezes.
  task automatic run(input int n, input int mode);
    int freeze = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (mode == 0) begin
        en = 1'b1;
      end else if (freeze > 0) begin
        en = 1'b0;
        freeze--;
      end else if ($urandom_range(0, 299) == 0) begin
        en = 1'b0;
        freeze = 49;
      end else begin
        en = ($urandom_range(0, 9) != 0);
      end
      @(posedge clk);
      #1 compare_all();
    end
  endtask

  initial begin
    reset_n = 1'b0;
    en      = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1 compare_all();
    end
    @(negedge clk);
    reset_n = 1'b1;
    en      = 1'b1;
    run(1300, 0);
    run(3000, 1);

    // Reset asserted between edges must clear outputs without a clock.
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 compare_all();
    repeat (3) begin
      @(posedge clk);
      #1 compare_all();
    end
    @(negedge clk);
    reset_n = 1'b1;
    en      = 1'b1;
    run(1500, 0);
    run(3000, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
